// File: rtl/mux_21_4_arbiter.sv
// Round-robin arbiter for two valid/grant requesters sharing one registered output word.
// Each requester gets at most BURST consecutive transfers while the other one waits.
module mux_21_4_arbiter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned BURST = 2
) (
  input  logic             clk,
  input  logic             Reset_L,
  input  logic             req_a,
  input  logic [WIDTH-1:0] A,
  output logic             gnt_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] B,
  output logic             gnt_b,
  output logic             S,
  output logic [WIDTH-1:0] Q,
  output logic             valid_out,
  input  logic             ready_in
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic               last, last_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;
  logic [WIDTH-1:0]   q_nxt;
  logic               valid_nxt;
  logic               free, xfer_a, xfer_b, burst_done;

  // Grants and select decode from registered state and downstream readiness only
  always_comb begin
    free    = !valid_out || ready_in;
    gnt_a   = (state == GNT_A) && free;
    gnt_b   = (state == GNT_B) && free;
    S       = (state == GNT_B);
    xfer_a  = req_a && gnt_a;
    xfer_b  = req_b && gnt_b;
    cnt_inc = cnt + CNT_W'(1);
  end

  // Next-state, burst counter and output holding register
  always_comb begin
    state_nxt  = state;
    last_nxt   = last;
    cnt_nxt    = cnt;
    q_nxt      = Q;
    valid_nxt  = valid_out;
    burst_done = 1'b0;

    if (xfer_a) begin
      q_nxt     = A;
      valid_nxt = 1'b1;
      last_nxt  = 1'b0;
    end else if (xfer_b) begin
      q_nxt     = B;
      valid_nxt = 1'b1;
      last_nxt  = 1'b1;
    end else if (valid_out && ready_in) begin
      valid_nxt = 1'b0;
    end

    if (xfer_a || xfer_b) begin
      cnt_nxt    = cnt_inc;
      burst_done = (cnt_inc == BURST_CNT);
    end

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (req_a && req_b)  state_nxt = last ? GNT_A : GNT_B;
        else if (req_a)      state_nxt = GNT_A;
        else if (req_b)      state_nxt = GNT_B;
      end
      GNT_A: begin
        if (free) begin
          if (!req_a) begin
            cnt_nxt   = '0;
            state_nxt = req_b ? GNT_B : IDLE;
          end else if (burst_done) begin
            cnt_nxt = '0;
            if (req_b) state_nxt = GNT_B;
          end
        end
      end
      GNT_B: begin
        if (free) begin
          if (!req_b) begin
            cnt_nxt   = '0;
            state_nxt = req_a ? GNT_A : IDLE;
          end else if (burst_done) begin
            cnt_nxt = '0;
            if (req_a) state_nxt = GNT_A;
          end
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State and data registers; last starts at B so A wins the first tie
  always_ff @(posedge clk or negedge Reset_L) begin
    if (!Reset_L) begin
      state     <= IDLE;
      last      <= 1'b1;
      cnt       <= '0;
      Q         <= '0;
      valid_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      cnt       <= cnt_nxt;
      Q         <= q_nxt;
      valid_out <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_mux_21_4_arbiter.sv
// Directed bench for mux_21_4_arbiter: a continuous scenario chain with hand-computed
// grant order, select and output words.
module tb_mux_21_4_arbiter;

  logic       clk;
  logic       Reset_L;
  logic       req_a, req_b, ready_in;
  logic [3:0] A, B;
  logic       gnt_a, gnt_b, S, valid_out;
  logic [3:0] Q;

  int vectors;
  int miscompares;

  mux_21_4_arbiter #(.WIDTH(4), .BURST(2)) dut (
    .clk       (clk),
    .Reset_L   (Reset_L),
    .req_a     (req_a),
    .A         (A),
    .gnt_a     (gnt_a),
    .req_b     (req_b),
    .B         (B),
    .gnt_b     (gnt_b),
    .S         (S),
    .Q         (Q),
    .valid_out (valid_out),
    .ready_in  (ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    Reset_L = 1'b0; req_a = 1'b0; req_b = 1'b0; ready_in = 1'b1; A = 4'h0; B = 4'h0;
    #3;
    vectors++;
    if ({Q, valid_out, S, gnt_a, gnt_b} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_outputs: Q=%h valid=%b S=%b gnt_a=%b gnt_b=%b, expected all 0",
               Q, valid_out, S, gnt_a, gnt_b);
    end
    tick; tick;
    Reset_L = 1'b1;
    tick;
    vectors++;
    if ({valid_out, S, gnt_a, gnt_b} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_idle: valid=%b S=%b gnt_a=%b gnt_b=%b, expected 0",
               valid_out, S, gnt_a, gnt_b);
    end
  endtask

  task automatic test_single;
    logic [3:0] exp_q [3] = '{4'h3, 4'h5, 4'h9};
    logic [3:0] nxt_a [3] = '{4'h5, 4'h9, 4'h9};
    req_a = 1'b1; A = 4'h3; req_b = 1'b0; ready_in = 1'b1;
    tick;
    vectors++;
    if (S !== 1'b0 || gnt_a !== 1'b1) begin
      miscompares++;
      $display("FAIL single_grant: S=%b gnt_a=%b, expected S=0 gnt_a=1", S, gnt_a);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      vectors++;
      if (Q !== exp_q[i] || valid_out !== 1'b1 || S !== 1'b0 || gnt_b !== 1'b0) begin
        miscompares++;
        $display("FAIL single_xfer%0d: Q=%h valid=%b S=%b gnt_b=%b, expected Q=%h valid=1 S=0 gnt_b=0",
                 i, Q, valid_out, S, gnt_b, exp_q[i]);
      end
      A = nxt_a[i];
    end
    req_a = 1'b0;
    tick;
    vectors++;
    if (valid_out !== 1'b0 || gnt_a !== 1'b0 || Q !== 4'h9) begin
      miscompares++;
      $display("FAIL single_drain: valid=%b gnt_a=%b Q=%h, expected valid=0 gnt_a=0 Q=9",
               valid_out, gnt_a, Q);
    end
  endtask

  // A was served last, so B wins the tie; both held gives B,B,A,A,B,B
  task automatic test_fairness;
    logic       exp_s [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] exp_q [6] = '{4'h8, 4'h9, 4'h1, 4'h2, 4'hA, 4'hB};
    logic ga, gb;
    A = 4'h1; B = 4'h8; req_a = 1'b1; req_b = 1'b1; ready_in = 1'b1;
    tick;
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (S !== exp_s[i]) begin
        miscompares++;
        $display("FAIL fair_sel%0d: S=%b expected %b", i, S, exp_s[i]);
      end
      ga = gnt_a; gb = gnt_b;
      tick;
      if (ga) A = A + 4'h1;
      if (gb) B = B + 4'h1;
      vectors++;
      if (Q !== exp_q[i] || valid_out !== 1'b1) begin
        miscompares++;
        $display("FAIL fair_q%0d: Q=%h valid=%b expected Q=%h valid=1", i, Q, valid_out, exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    ready_in = 1'b0;
    #1;
    vectors++;
    if (gnt_a !== 1'b0 || gnt_b !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_gnt: gnt_a=%b gnt_b=%b expected 0 0", gnt_a, gnt_b);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      vectors++;
      if (Q !== 4'hB || valid_out !== 1'b1 || gnt_a !== 1'b0 || gnt_b !== 1'b0 || S !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold%0d: Q=%h valid=%b gnt_a=%b gnt_b=%b S=%b expected Q=b valid=1 gnt 0 0 S=0",
                 i, Q, valid_out, gnt_a, gnt_b, S);
      end
    end
    ready_in = 1'b1;
    #1;
    vectors++;
    if (gnt_a !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_resume_gnt: gnt_a=%b expected 1", gnt_a);
    end
    tick;
    vectors++;
    if (Q !== 4'h3) begin
      miscompares++;
      $display("FAIL bp_resume_q0: Q=%h expected 3", Q);
    end
    A = 4'h4;
    tick;
    A = 4'h5;
    vectors++;
    if (Q !== 4'h4 || S !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_resume_q1: Q=%h S=%b expected Q=4 S=1", Q, S);
    end
  endtask

  task automatic test_simul_load;
    vectors++;
    if (valid_out !== 1'b1 || gnt_b !== 1'b1 || B !== 4'hC) begin
      miscompares++;
      $display("FAIL simul_pre: valid=%b gnt_b=%b B=%h expected valid=1 gnt_b=1 B=c", valid_out, gnt_b, B);
    end
    tick;
    vectors++;
    if (Q !== 4'hC || valid_out !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_load: Q=%h valid=%b expected Q=c valid=1", Q, valid_out);
    end
    B = 4'hD;
  endtask

  task automatic test_early_drop;
    tick;
    B = 4'hE;
    vectors++;
    if (Q !== 4'hD || S !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_pre: Q=%h S=%b expected Q=d S=0", Q, S);
    end
    tick;
    vectors++;
    if (Q !== 4'h5) begin
      miscompares++;
      $display("FAIL drop_a1: Q=%h expected 5", Q);
    end
    req_a = 1'b0;
    tick;
    vectors++;
    if (S !== 1'b1 || valid_out !== 1'b0 || Q !== 4'h5 || gnt_b !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_switch: S=%b valid=%b Q=%h gnt_b=%b expected S=1 valid=0 Q=5 gnt_b=1",
               S, valid_out, Q, gnt_b);
    end
    tick;
    vectors++;
    if (Q !== 4'hE || S !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_b1: Q=%h S=%b expected Q=e S=1", Q, S);
    end
    B = 4'hF; req_a = 1'b1; A = 4'h6;
    tick;
    vectors++;
    if (Q !== 4'hF || S !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_b2: Q=%h S=%b expected Q=f S=0", Q, S);
    end
  endtask

  task automatic test_reset_midstream;
    Reset_L = 1'b0;
    #2;
    vectors++;
    if (Q !== 4'h0 || valid_out !== 1'b0 || S !== 1'b0 || gnt_a !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_async: Q=%h valid=%b S=%b gnt_a=%b expected all 0", Q, valid_out, S, gnt_a);
    end
    A = 4'h7; B = 4'h2; req_a = 1'b1; req_b = 1'b1;
    tick;
    Reset_L = 1'b1;
    tick;
    vectors++;
    if (S !== 1'b0 || gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_first_grant: S=%b gnt_a=%b gnt_b=%b expected S=0 gnt_a=1 gnt_b=0", S, gnt_a, gnt_b);
    end
    tick;
    vectors++;
    if (Q !== 4'h7 || valid_out !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_first_xfer: Q=%h valid=%b expected Q=7 valid=1", Q, valid_out);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset;
    test_single;
    test_fairness;
    test_backpressure;
    test_simul_load;
    test_early_drop;
    test_reset_midstream;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
